// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
//   state_t      : 2-bit FSM encoding, also exported on state_o
//   cnt_width()  : counter width for a given maximum count (never below 1 bit)
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StFilter   = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val-1; at least one bit so vectors stay legal.
  function automatic int unsigned cnt_width(int unsigned max_val);
    if (max_val <= 2) begin
      return 1;
    end
    return $clog2(max_val);
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Status/control bundle between clk_gen-side logic, the reset sequencer and its consumers.
//   locked_in   : async lock flag from clk_gen
//   force_rst   : synchronous request holding every stage in reset
//   rst_stage_n : per-stage active-low resets, bit 0 released first
//   all_ready   : every stage released
//   state_o     : sequencer FSM state
//   loss_count  : saturating lock-loss count
// master = the sequencer, slave = whoever drives the inputs and watches the resets.
interface rst_sequencer_if #(
  parameter int unsigned N_STAGES   = 3,
  parameter int unsigned LOSS_CNT_W = 8
);
  logic                  locked_in;
  logic                  force_rst;
  logic [N_STAGES-1:0]   rst_stage_n;
  logic                  all_ready;
  logic [1:0]            state_o;
  logic [LOSS_CNT_W-1:0] loss_count;

  modport master (
    input  locked_in,
    input  force_rst,
    output rst_stage_n,
    output all_ready,
    output state_o,
    output loss_count
  );

  modport slave (
    output locked_in,
    output force_rst,
    input  rst_stage_n,
    input  all_ready,
    input  state_o,
    input  loss_count
  );
endinterface

// File: rtl/bit_sync.sv
// Flop-chain synchroniser for asynchronous level signals.
//   clk, rst_n : system clock, synchronous active-low clear
//   d_i        : asynchronous input
//   q_o        : d_i delayed through STAGES flops
module bit_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: synchronises and filters clk_gen's lock flag, then releases
// N_STAGES active-low resets in order, STAGE_DELAY cycles apart. Lock loss or force_rst
// drops every stage at once; lock losses seen in RUN are counted (saturating).
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : master side of rst_sequencer_if (locked_in/force_rst in, resets and status out)
// All outputs come straight from flops.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 1024,
  parameter int unsigned STAGE_DELAY = 256,
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned LOSS_CNT_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  rst_sequencer_if.master bus
);

  localparam int unsigned CntMax = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
  localparam int unsigned CntW   = cnt_width(CntMax);
  localparam int unsigned IdxW   = cnt_width(N_STAGES);

  localparam logic [CntW-1:0] FilterLast = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0] DelayLast  = CntW'(STAGE_DELAY - 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_STAGES - 1);

  logic lock_s;

  bit_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.locked_in),
    .q_o   (lock_s)
  );

  state_t                state_d, state_q;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic [IdxW-1:0]       idx_d, idx_q;
  logic [N_STAGES-1:0]   stage_d, stage_q;
  logic                  ready_d, ready_q;
  logic [LOSS_CNT_W-1:0] loss_d, loss_q;
  logic                  abort;

  assign abort = !lock_s || bus.force_rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    loss_d  = loss_q;

    unique case (state_q)
      StWaitLock: begin
        if (!abort) begin
          state_d = StFilter;
          cnt_d   = '0;
        end
      end

      StFilter: begin
        if (abort) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == FilterLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRelease: begin
        if (abort) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end else if (cnt_q == DelayLast) begin
          cnt_d = '0;
          // Only the indexed bit is set, so stages can only release in order.
          for (int i = 0; i < int'(N_STAGES); i++) begin
            if (idx_q == IdxW'(i)) begin
              stage_d[i] = 1'b1;
            end
          end
          if (idx_q == LastIdx) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRun: begin
        if (abort) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
          // Count true lock losses only, even if force_rst coincides.
          if (!lock_s && (loss_q != '1)) begin
            loss_d = loss_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StWaitLock;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  assign bus.rst_stage_n = stage_q;
  assign bus.all_ready   = ready_q;
  assign bus.state_o     = state_q;
  assign bus.loss_count  = loss_q;

endmodule
